// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port sequencer in front of a single-port DataMemory.
// Optional WAIT timeout with err pulse is enabled by defining DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter #(
   parameter int DW       = 32,
   parameter int AW       = 32,
   parameter int MIN_WAIT = 1,
   parameter int MAX_WAIT = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic          err0,
   output logic          err1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          stall0,
   output logic          stall1,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready
);
`ifdef DMEM_ARB_TIMEOUT_EN
   localparam logic TMO_EN = 1'b1;
`else
   localparam logic TMO_EN = 1'b0;
`endif
   typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;
   state_t        state_q, state_d;
   logic          grant_q, grant_d, last_q, last_d, we_q, we_d, err_q, err_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          ready_ok, timeout, pick;
   assign ready_ok = mem_ready && (({1'b0, cnt_q} + 9'd1) >= 9'(MIN_WAIT));
   assign timeout  = TMO_EN && !ready_ok && (cnt_q == 8'(MAX_WAIT - 1));
   // on a tie the port that did not win last time goes first
   assign pick     = (req0 && req1) ? ~last_q : req1;
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      we_d     = we_q;
      err_d    = err_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      cnt_d    = cnt_q;
      case (state_q)
         IDLE: if (req0 || req1) begin
            grant_d = pick;
            last_d  = pick;
            we_d    = pick ? we1 : we0;
            addr_d  = pick ? addr1 : addr0;
            wdata_d = pick ? wdata1 : wdata0;
            err_d   = 1'b0;
            state_d = SETUP;
         end
         SETUP: begin
            cnt_d   = 8'd0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
            if (ready_ok) begin
               if (!we_q && grant_q) rdata1_d = mem_rdata;
               if (!we_q && !grant_q) rdata0_d = mem_rdata;
               state_d = DONE;
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         grant_q  <= 1'b0;
         last_q   <= 1'b1;
         we_q     <= 1'b0;
         err_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         cnt_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         we_q     <= we_d;
         err_q    <= err_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         cnt_q    <= cnt_d;
      end
   end
   assign ack0      = (state_q == DONE) && !grant_q;
   assign ack1      = (state_q == DONE) && grant_q;
   assign err0      = TMO_EN && ack0 && err_q;
   assign err1      = TMO_EN && ack1 && err_q;
   assign mem_we    = (state_q == DONE) && we_q && !err_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign stall0    = req0 && !ack0;
   assign stall1    = req1 && !ack1;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of grant order, latency, writes, timeout and reset for dmem_arbiter.
module tb_dmem_arbiter;
`ifdef DMEM_ARB_TIMEOUT_EN
   localparam int TB_MAX = 4;
`else
   localparam int TB_MAX = 64;
`endif
   logic        clk = 1'b0;
   logic        reset, req0, req1, we0, we1, mem_ready;
   logic [31:0] addr0, addr1, wdata0, wdata1, mem_rdata;
   logic        ack0, ack1, err0, err1, stall0, stall1, mem_we;
   logic [31:0] rdata0, rdata1, mem_addr, mem_wdata;
   logic [31:0] ram [0:63];
   int          errs = 0, checks = 0;
   int          lat, wc, sb, n, nacks, last_n, gap_bad, dbl, addr_bad;
   logic        err_at, we_at, pa;
   logic [3:0]  seq;

   dmem_arbiter #(.DW(32), .AW(32), .MIN_WAIT(1), .MAX_WAIT(TB_MAX)) dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
      .rdata0(rdata0), .rdata1(rdata1), .stall0(stall0), .stall1(stall1),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
   assign mem_rdata = ram[mem_addr[7:2]];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // one access on port p; mem_ready rises at cycle rdy_at (0 = already high)
   task automatic xfer(input bit p, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input int rdy_at, output int l, output int wcnt, output int sbad,
                       output logic e, output logic wa);
      logic ak, st;
      if (p) begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
      else begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
      mem_ready = (rdy_at == 0);
      l = 0; wcnt = 0; sbad = 0; e = 0; wa = 0;
      while (l < 100) begin
         @(negedge clk);
         l++;
         ak = p ? ack1 : ack0;
         st = p ? stall1 : stall0;
         if (mem_we) wcnt++;
         if (st !== ~ak) sbad++;
         if (l == rdy_at) mem_ready = 1;
         if (ak) begin e = p ? err1 : err0; wa = mem_we; break; end
      end
      if (p) req1 = 0; else req0 = 0;
      @(negedge clk);
      if (mem_we) wcnt++;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = 32'h0;
      ram[4] = 32'hDEADBEEF;
      ram[5] = 32'hCAFEF00D;
      reset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; mem_ready = 1;
      addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
      repeat (2) @(negedge clk);
      reset = 0;
      @(negedge clk);
      chk("rst_ack", {ack1, ack0}, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_rdata", rdata0 | rdata1, 0);
      chk("rst_stall", {stall1, stall0}, 0);

      xfer(0, 0, 32'h10, 0, 0, lat, wc, sb, err_at, we_at);
      chk("t1_lat", lat, 3);
      chk("t1_rdata0", rdata0, 32'hDEADBEEF);
      chk("t1_nowe", wc, 0);
      chk("t1_stall", sb, 0);
      chk("t1_err", err_at, 0);

      xfer(1, 1, 32'h20, 32'h12345678, 0, lat, wc, sb, err_at, we_at);
      chk("t2_lat", lat, 3);
      chk("t2_wecnt", wc, 1);
      chk("t2_we_done", we_at, 1);
      chk("t2_ram", ram[8], 32'h12345678);
      xfer(0, 0, 32'h20, 0, 0, lat, wc, sb, err_at, we_at);
      chk("t2_rd_back", rdata0, 32'h12345678);
      chk("t2_rdata1", rdata1, 0);

      reset = 1;
      @(negedge clk);
      reset = 0;
      req0 = 1; we0 = 0; addr0 = 32'h10; req1 = 1; we1 = 0; addr1 = 32'h14; mem_ready = 1;
      seq = 0; n = 0; nacks = 0; last_n = 0; gap_bad = 0; dbl = 0; sb = 0; pa = 0;
      while (nacks < 4 && n < 100) begin
         @(negedge clk);
         n++;
         if (ack0 && ack1) dbl++;
         if ((ack0 || ack1) && pa) dbl++;
         pa = ack0 || ack1;
         if (stall0 !== ~ack0 || stall1 !== ~ack1) sb++;
         if (ack0 || ack1) begin
            seq = {seq[2:0], ack1};
            if (n - last_n != (nacks == 0 ? 3 : 4)) gap_bad++;
            last_n = n;
            nacks++;
         end
      end
      req0 = 0; req1 = 0;
      @(negedge clk);
      chk("t3_order", seq, 4'b0101);
      chk("t3_spacing", gap_bad, 0);
      chk("t3_single", dbl, 0);
      chk("t3_stall", sb, 0);
      chk("t3_rdata0", rdata0, 32'hDEADBEEF);
      chk("t3_rdata1", rdata1, 32'hCAFEF00D);

      xfer(0, 0, 32'h20, 0, 12, lat, wc, sb, err_at, we_at);
`ifdef DMEM_ARB_TIMEOUT_EN
      chk("t4_lat", lat, 6);
      chk("t4_err", err_at, 1);
      chk("t4_rdata0", rdata0, 32'hDEADBEEF);
`else
      chk("t4_lat", lat, 13);
      chk("t4_err", err_at, 0);
      chk("t4_rdata0", rdata0, 32'h12345678);
`endif
      chk("t4_nowe", wc, 0);

      mem_ready = 0; req0 = 1; we0 = 0; addr0 = 32'h10;
      n = 0; addr_bad = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (mem_addr !== 32'h10) addr_bad++;
         if (ack0) break;
         if (n == 2) begin addr0 = 32'h14; req0 = 0; end
         if (n == 4) mem_ready = 1;
      end
      @(negedge clk);
      chk("t5_lat", n, 5);
      chk("t5_addr", addr_bad, 0);
      chk("t5_rdata0", rdata0, 32'hDEADBEEF);

      mem_ready = 0; req1 = 1; we1 = 0; addr1 = 32'h10;
      repeat (2) @(negedge clk);
      reset = 1; req1 = 0;
      @(negedge clk);
      reset = 0;
      chk("t6_ack", {ack1, ack0}, 0);
      chk("t6_we", mem_we, 0);
      chk("t6_rdata", {rdata1 != 0, rdata0 != 0}, 0);
      chk("t6_addr", mem_addr, 0);
      req0 = 1; addr0 = 32'h14; req1 = 1; addr1 = 32'h20; mem_ready = 1;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (ack0 || ack1) break;
      end
      chk("t6_tie", {ack1, ack0}, 2'b01);
      chk("t6_lat", n, 3);
      chk("t6_rdata0", rdata0, 32'hCAFEF00D);
      req0 = 0; req1 = 0;
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
